// File: rtl/adder_tree_acc_pkg.sv
// Shared constants and helpers for the adder-tree accumulator slice.
package adder_tree_acc_pkg;

  localparam int unsigned W_PSUM = 32;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } sideband_t;

  // Number of pairwise levels needed to reduce n lanes to one (ceil(log2(n))).
  function automatic int unsigned tree_levels(input int unsigned n);
    int unsigned l;
    l = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) < n) l = i + 1;
    end
    return l;
  endfunction

endpackage

// File: rtl/adder_tree_acc_level.sv
// One registered pairwise level of the adder tree: N_PAIR sums of adjacent
// signed W_I-bit lanes, each widened to W_I+1 bits with no truncation.
module adder_tree_level
  import adder_tree_acc_pkg::*;
#(
  parameter int unsigned N_PAIR = 1,
  parameter int unsigned W_I    = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [2*N_PAIR*W_I-1:0]     d_flat,
  output logic [N_PAIR*(W_I+1)-1:0]   q_flat
);

  logic [N_PAIR*(W_I+1)-1:0] sum_d;
  logic [N_PAIR*(W_I+1)-1:0] sum_q;

  always_comb begin
    sum_d = '0;
    for (int unsigned p = 0; p < N_PAIR; p++) begin
      sum_d[p*(W_I+1) +: (W_I+1)] =
        (W_I+1)'(signed'(d_flat[(2*p)*W_I +: W_I])) +
        (W_I+1)'(signed'(d_flat[(2*p+1)*W_I +: W_I]));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign q_flat = sum_q;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree feeding a grouped accumulator (first/last framing).
// Optional clamp-on-overflow with sticky sat_o when ADDER_TREE_SAT_EN is defined.
module adder_tree_acc
  import adder_tree_acc_pkg::*;
#(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned W_IN  = 20,
  parameter int unsigned W_OUT = W_PSUM
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   vld_i,
  input  logic                   first_i,
  input  logic                   last_i,
  input  logic [N_IN*W_IN-1:0]   in_flat,
  output logic [W_OUT-1:0]       acc_o,
  output logic                   vld_o,
  output logic                   sat_o
);

  localparam int unsigned L   = tree_levels(N_IN);
  localparam int unsigned W_S = W_IN + L;

  // Tree levels: level j consumes N_IN>>j lanes of W_IN+j bits.
  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int unsigned NP = N_IN >> (j + 1);
    localparam int unsigned WI = W_IN + j;
    logic [2*NP*WI-1:0]   d;
    logic [NP*(WI+1)-1:0] q;
    if (j == 0) begin : g_src_in
      assign d = in_flat;
    end else begin : g_src_lvl
      assign d = g_lvl[j-1].q;
    end
    adder_tree_level #(.N_PAIR(NP), .W_I(WI)) u_lvl (
      .clk    (clk),
      .rstn   (rstn),
      .d_flat (d),
      .q_flat (q)
    );
  end

  logic signed [W_S-1:0] tree_s;
  assign tree_s = g_lvl[L-1].q;

  // Sideband pipeline kept in lockstep with the tree registers.
  sideband_t sb_d [L];
  sideband_t sb_q [L];

  always_comb begin
    sb_d[0] = '{vld: vld_i, first: first_i, last: last_i};
    for (int unsigned i = 1; i < L; i++) sb_d[i] = sb_q[i-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < L; i++) sb_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < L; i++) sb_q[i] <= sb_d[i];
    end
  end

  sideband_t tsb;
  assign tsb = sb_q[L-1];

  logic signed [W_OUT-1:0] s_ext;
  logic signed [W_OUT-1:0] base;
  logic signed [W_OUT-1:0] acc_next;
  logic signed [W_OUT-1:0] acc_d, acc_q;
  logic signed [W_OUT-1:0] acc_out_d, acc_out_q;
  logic                    vld_o_d, vld_o_q;

  assign s_ext = W_OUT'(tree_s);
  assign base  = tsb.first ? '0 : acc_q;

`ifdef ADDER_TREE_SAT_EN
  logic [W_OUT:0] wide;
  logic           clamp;
  logic           grp_sat_d, grp_sat_q;
  logic           sat_out_d, sat_out_q;

  // One guard bit detects overflow; clamp toward the sign of the true sum.
  always_comb begin
    wide  = {base[W_OUT-1], base} + {s_ext[W_OUT-1], s_ext};
    clamp = wide[W_OUT] ^ wide[W_OUT-1];
    if (clamp) acc_next = wide[W_OUT] ? {1'b1, {(W_OUT-1){1'b0}}}
                                      : {1'b0, {(W_OUT-1){1'b1}}};
    else       acc_next = wide[W_OUT-1:0];
  end

  always_comb begin
    grp_sat_d = grp_sat_q;
    sat_out_d = sat_out_q;
    if (tsb.vld) begin
      grp_sat_d = (tsb.first ? 1'b0 : grp_sat_q) | clamp;
      if (tsb.last) sat_out_d = grp_sat_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grp_sat_q <= 1'b0;
      sat_out_q <= 1'b0;
    end else begin
      grp_sat_q <= grp_sat_d;
      sat_out_q <= sat_out_d;
    end
  end

  assign sat_o = sat_out_q;
`else
  always_comb acc_next = base + s_ext;

  assign sat_o = 1'b0;
`endif

  always_comb begin
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    vld_o_d   = 1'b0;
    if (tsb.vld) begin
      acc_d = acc_next;
      if (tsb.last) begin
        vld_o_d   = 1'b1;
        acc_out_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      acc_out_q <= '0;
      vld_o_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      vld_o_q   <= vld_o_d;
    end
  end

  assign acc_o = acc_out_q;
  assign vld_o = vld_o_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc: randomized and directed groups checked
// against a plain-arithmetic group-sum model (honours ADDER_TREE_SAT_EN).
module tb_adder_tree_acc;

  localparam int N_IN  = 16;
  localparam int W_IN  = 20;
  localparam int W_OUT = 24;
  localparam int L     = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 vld_i = 1'b0;
  logic                 first_i = 1'b0;
  logic                 last_i = 1'b0;
  logic [N_IN*W_IN-1:0] in_flat = '0;
  logic [W_OUT-1:0]     acc_o;
  logic                 vld_o;
  logic                 sat_o;

  adder_tree_acc #(.N_IN(N_IN), .W_IN(W_IN), .W_OUT(W_OUT)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .vld_i   (vld_i),
    .first_i (first_i),
    .last_i  (last_i),
    .in_flat (in_flat),
    .acc_o   (acc_o),
    .vld_o   (vld_o),
    .sat_o   (sat_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint acc;
    bit     sat;
    int     cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  longint lanes[N_IN];
  longint m_acc = 0;
  bit     m_sat = 1'b0;

  localparam longint HI  = (longint'(1) << (W_OUT-1)) - 1;
  localparam longint LO  = -(longint'(1) << (W_OUT-1));
  localparam longint MOD = longint'(1) << W_OUT;

  // Reduce an exact sum into the W_OUT-bit result range (clamp or wrap).
  function automatic longint fit(input longint v, output bit clipped);
    longint m;
    clipped = 1'b0;
`ifdef ADDER_TREE_SAT_EN
    if (v > HI) begin clipped = 1'b1; return HI; end
    if (v < LO) begin clipped = 1'b1; return LO; end
    return v;
`else
    m = v % MOD;
    if (m < 0)  m = m + MOD;
    if (m > HI) m = m - MOD;
    return m;
`endif
  endfunction

  task automatic send(input bit v, input bit f, input bit l);
    longint s;
    bit     c;
    for (int k = 0; k < N_IN; k++) in_flat[k*W_IN +: W_IN] = lanes[k][W_IN-1:0];
    vld_i   = v;
    first_i = f;
    last_i  = l;
    if (v) begin
      s = 0;
      for (int k = 0; k < N_IN; k++) s += lanes[k];
      if (f) begin
        m_acc = fit(s, c);
        m_sat = c;
      end else begin
        m_acc = fit(m_acc + s, c);
        m_sat = m_sat | c;
      end
      if (l) exp_q.push_back('{acc: m_acc, sat: m_sat, cyc: cyc + L + 1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_const(input longint v);
    for (int k = 0; k < N_IN; k++) lanes[k] = v;
  endtask

  task automatic set_rand();
    logic signed [W_IN-1:0] r;
    for (int k = 0; k < N_IN; k++) begin
      r = W_IN'($urandom);
      lanes[k] = r;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_rand();
      send(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      idle(1);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input longint got, input longint req);
    n_cmp++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Monitor: pop on every vld_o; otherwise outputs must hold the last result.
  longint h_acc = 0;
  bit     h_sat = 1'b0;
  always @(negedge clk) begin
    exp_t   e;
    longint got;
    got = longint'($signed(acc_o));
    if (!rstn) begin
      h_acc = 0;
      h_sat = 1'b0;
    end
    if (vld_o) begin
      n_cmp++;
      if (!rstn || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_vld_o: got vld_o=1 at cycle %0d, required 0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (got != e.acc || sat_o != e.sat || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL result: got acc_o=%0d sat_o=%0d cycle=%0d, required acc_o=%0d sat_o=%0d cycle=%0d",
                   got, sat_o, cyc, e.acc, e.sat, e.cyc);
        end
        h_acc = e.acc;
        h_sat = e.sat;
      end
    end else begin
      n_cmp++;
      if (got != h_acc || sat_o != h_sat) begin
        n_fail++;
        $display("FAIL hold: got acc_o=%0d sat_o=%0d at cycle %0d, required acc_o=%0d sat_o=%0d",
                 got, sat_o, cyc, h_acc, h_sat);
      end
    end
  end

  initial begin
    set_const(0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("reset_acc_o", longint'($signed(acc_o)), 0);
    chk("reset_vld_o", longint'(vld_o), 0);
    chk("reset_sat_o", longint'(sat_o), 0);

    // Beats with no first after reset accumulate onto zero.
    set_rand(); send(1'b1, 1'b0, 1'b0);
    set_rand(); send(1'b1, 1'b0, 1'b1);

    // Single-beat group, all lanes 1.
    set_const(1); send(1'b1, 1'b1, 1'b1);
    idle(2);

    // Three beats of the repeating -3,-2,5 lane pattern.
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < N_IN; k++) lanes[k] = (k % 3 == 0) ? -3 : (k % 3 == 1) ? -2 : 5;
      send(1'b1, b == 0, b == 2);
    end

    // Back-to-back single-beat groups.
    set_const(100); send(1'b1, 1'b1, 1'b1);
    set_const(7);   send(1'b1, 1'b1, 1'b1);

    // Group with invalid garbage beats interleaved.
    set_const(5);   send(1'b1, 1'b1, 1'b0);
    idle(3);
    set_const(-9);  send(1'b1, 1'b0, 1'b0);
    idle(1);
    set_const(11);  send(1'b1, 1'b0, 1'b1);

    // Restart: a first beat abandons the open group.
    set_rand(); send(1'b1, 1'b1, 1'b0);
    set_rand(); send(1'b1, 1'b0, 1'b0);
    set_rand(); send(1'b1, 1'b1, 1'b0);
    set_rand(); send(1'b1, 1'b0, 1'b1);

    // Reset mid-group, then a one-beat group of lanes 2.
    drain();
    set_const(3); send(1'b1, 1'b1, 1'b0);
    set_const(3); send(1'b1, 1'b0, 1'b0);
    vld_i = 1'b0;
    rstn  = 1'b0;
    m_acc = 0;
    m_sat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    set_const(2); send(1'b1, 1'b1, 1'b1);

    // Maximum-positive lanes overflow the accumulator.
    set_const((longint'(1) << (W_IN-1)) - 1);
    for (int b = 0; b < 4; b++) send(1'b1, b == 0, b == 3);
    set_rand(); send(1'b1, 1'b1, 1'b1);

    // Randomized traffic with random framing and gaps.
    for (int i = 0; i < 400; i++) begin
      set_rand();
      send($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end

    drain();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_tree_acc.md
ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

Interface
REQ-001 Parameter N_IN, default 16: number of input lanes; power of two, 2..64.
REQ-002 Parameter W_IN, default 20: signed lane width.
REQ-003 Parameter W_OUT, default W_PSUM (shared constant): signed accumulator/output width; W_OUT >= W_IN+log2(N_IN).
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 vld_i  input  1  lane data valid this cycle.
REQ-007 first_i  input  1  first beat of an accumulation group; qualified by vld_i.
REQ-008 last_i  input  1  last beat of an accumulation group; qualified by vld_i.
REQ-009 in_flat  input  N_IN*W_IN  packed signed lanes; lane k occupies bits [k*W_IN +: W_IN].
REQ-010 acc_o  output  W_OUT  signed group result.
REQ-011 vld_o  output  1  one-cycle strobe marking acc_o as a completed group.
REQ-012 sat_o  output  1  group saturated; constant 0 without ADDER_TREE_SAT_EN.

Function
REQ-013 The tree SHALL have L = log2(N_IN) registered levels; level j SHALL add adjacent pairs at width W_IN+j, sign-extended, with no truncation.
REQ-014 vld_i, first_i and last_i SHALL travel through an L-stage sideband pipeline aligned with the tree data.
REQ-015 Level registers SHALL update every cycle regardless of valid; downstream logic SHALL ignore data that is not valid.
REQ-016 The tree sum S SHALL be sign-extended to W_OUT before accumulation.
REQ-017 On a valid tree output with first set, acc SHALL load S; with first clear, acc SHALL become acc+S.
REQ-018 Invalid tree outputs SHALL leave acc, acc_o and sat_o unchanged.
REQ-019 On a valid tree output with last set, the next edge SHALL set vld_o=1 for one cycle, with acc_o equal to the group total; total latency from vld_i to vld_o SHALL be L+1 cycles.
REQ-020 acc_o SHALL hold its value until the next completed group.
REQ-021 A beat with first_i and last_i both set SHALL produce acc_o=S, a one-beat group.
REQ-022 A first beat arriving while a group is open SHALL discard the partial sum and restart; no vld_o SHALL be issued for the abandoned group.
REQ-023 A beat with last set before any first after reset SHALL accumulate onto acc=0.
REQ-024 The block SHALL accept back-to-back valid beats every cycle with no bubbles, including last followed immediately by first.
REQ-025 Without ADDER_TREE_SAT_EN, accumulation overflow SHALL wrap modulo 2^W_OUT.

Reset
REQ-026 When rstn is low: all tree registers, sideband pipeline, acc, acc_o and sat_o SHALL clear to 0 and vld_o SHALL be 0.
REQ-027 Reset asserted mid-group SHALL discard the group; the first vld_o after release SHALL come only from beats presented after release.

Configuration
REQ-028 Macro ADDER_TREE_SAT_EN defined: acc+S SHALL clamp to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
REQ-029 With ADDER_TREE_SAT_EN, any clamp SHALL set a sticky group flag, cleared by a first beat; sat_o SHALL be updated with acc_o on vld_o.
REQ-030 Macro ADDER_TREE_SAT_EN undefined: no clamp logic SHALL exist, and sat_o SHALL be tied to 0.

Structure
REQ-031 W_PSUM and a clog2-style level-count helper SHALL reside in the shared controller parameter package/header.
REQ-032 One sub-module, adder_tree_level, SHALL implement one registered pairwise level (parameters: pair count and input width).
REQ-033 The top SHALL instantiate L levels via generate, plus the accumulator stage.

Verification
REQ-034 N_IN=16, all lanes 1, vld_i/first_i/last_i=1 for one beat -> vld_o once, 5 cycles later, acc_o=16.
REQ-035 Three beats of lanes -3, -2, 5 (repeating) with first on beat 0 and last on beat 2 -> single vld_o; acc_o = 3 beat-sums added together (exact value computed by the model).
REQ-036 Two groups back-to-back, (last,first) on consecutive cycles, lanes 100 then 7 -> two vld_o strobes 1 cycle apart, acc_o=1600 then 112.
REQ-037 Beats with vld_i=0 inserted between group beats, carrying garbage lane data -> acc_o unaffected by the garbage.
REQ-038 Reset pulsed after 2 beats of an open group, then a 1-beat group of lanes 2 -> only vld_o carries acc_o=32.
REQ-039 W_OUT=24, repeated maximum-positive lanes -> with ADDER_TREE_SAT_EN, acc_o=8388607 and sat_o=1; without it, the wrapped value with sat_o=0.
